// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - Master-side and memory-side signals of the two-master memory port arbiter
interface mem_port_arbiter_if;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_ren, s_wen;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic [31:0] s_rdata;
  logic        owner;

  // Environment side: requesting masters plus the memory returning read data.
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_be, m1_be, s_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           s_ren, s_wen, s_addr, s_wdata, s_be, owner
  );

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, m0_be, m1_be, s_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           s_ren, s_wen, s_addr, s_wdata, s_be, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Round-robin two-master arbiter with burst limit for the shared memory data port
module mem_port_arbiter #(
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              resetn,
  mem_port_arbiter_if.slave bus
);
  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  logic                last_owner;
  logic [7:0]          burst_cnt;
  logic [READ_LAT-1:0] tag_valid;
  logic [READ_LAT-1:0] tag_id;

  logic any_req;
  logic grant;
  logic winner;
  logic grant_we;
  logic tie_other;

  // burst_cnt is 0 only after reset or an idle cycle, so it doubles as the "fresh tie" flag.
  always_comb begin
    any_req   = bus.m0_req | bus.m1_req;
    grant     = resetn & any_req;
    tie_other = (burst_cnt == 8'd0) || (burst_cnt == BURST_LIM);
    if (bus.m0_req && bus.m1_req) begin
      winner = tie_other ? ~last_owner : last_owner;
    end else begin
      winner = bus.m1_req;
    end
    grant_we = winner ? bus.m1_we : bus.m0_we;
  end

  assign bus.m0_gnt  = grant & ~winner;
  assign bus.m1_gnt  = grant & winner;
  assign bus.owner   = grant ? winner : last_owner;
  assign bus.s_ren   = grant & ~grant_we;
  assign bus.s_wen   = grant & grant_we;
  assign bus.s_addr  = grant ? (winner ? bus.m1_addr  : bus.m0_addr)  : 32'd0;
  assign bus.s_wdata = grant ? (winner ? bus.m1_wdata : bus.m0_wdata) : 32'd0;
  assign bus.s_be    = grant ? (winner ? bus.m1_be    : bus.m0_be)    : 4'd0;

  assign bus.m0_rvalid = tag_valid[READ_LAT-1] & ~tag_id[READ_LAT-1];
  assign bus.m1_rvalid = tag_valid[READ_LAT-1] & tag_id[READ_LAT-1];
  assign bus.m0_rdata  = bus.m0_rvalid ? bus.s_rdata : 32'd0;
  assign bus.m1_rdata  = bus.m1_rvalid ? bus.s_rdata : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_owner <= 1'b1;
      burst_cnt  <= 8'd0;
      tag_valid  <= '0;
      tag_id     <= '0;
    end else begin
      if (grant) begin
        if (winner == last_owner && burst_cnt != 8'd0) begin
          if (burst_cnt != BURST_LIM) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end else begin
          burst_cnt <= 8'd1;
        end
        last_owner <= winner;
      end else begin
        burst_cnt <= 8'd0;
      end
      tag_valid[0] <= grant & ~grant_we;
      tag_id[0]    <= winner;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Vector table, directed corners and random traffic against a reference model
module tb_mem_port_arbiter;
  localparam int RL_A = 1;
  localparam int MB_A = 4;
  localparam int RL_B = 3;
  localparam int MB_B = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0, s_rdata = '0;
  logic [3:0]  m0_be = '0, m1_be = '0;

  mem_port_arbiter_if ia ();
  mem_port_arbiter_if ib ();

  assign ia.m0_req = m0_req;     assign ib.m0_req = m0_req;
  assign ia.m1_req = m1_req;     assign ib.m1_req = m1_req;
  assign ia.m0_we = m0_we;       assign ib.m0_we = m0_we;
  assign ia.m1_we = m1_we;       assign ib.m1_we = m1_we;
  assign ia.m0_addr = m0_addr;   assign ib.m0_addr = m0_addr;
  assign ia.m1_addr = m1_addr;   assign ib.m1_addr = m1_addr;
  assign ia.m0_wdata = m0_wdata; assign ib.m0_wdata = m0_wdata;
  assign ia.m1_wdata = m1_wdata; assign ib.m1_wdata = m1_wdata;
  assign ia.m0_be = m0_be;       assign ib.m0_be = m0_be;
  assign ia.m1_be = m1_be;       assign ib.m1_be = m1_be;
  assign ia.s_rdata = s_rdata;   assign ib.s_rdata = s_rdata;

  mem_port_arbiter #(.READ_LAT(RL_A), .MAX_BURST(MB_A)) dut_a (.clk(clk), .resetn(resetn), .bus(ia));
  mem_port_arbiter #(.READ_LAT(RL_B), .MAX_BURST(MB_B)) dut_b (.clk(clk), .resetn(resetn), .bus(ib));

  typedef struct packed {
    logic        g0, g1, rv0, rv1, ren, wen, own;
    logic [31:0] rd0, rd1, addr, wdata;
    logic [3:0]  be;
  } obs_t;

  obs_t obs_a, obs_b;
  assign obs_a = {ia.m0_gnt, ia.m1_gnt, ia.m0_rvalid, ia.m1_rvalid, ia.s_ren, ia.s_wen, ia.owner,
                  ia.m0_rdata, ia.m1_rdata, ia.s_addr, ia.s_wdata, ia.s_be};
  assign obs_b = {ib.m0_gnt, ib.m1_gnt, ib.m0_rvalid, ib.m1_rvalid, ib.s_ren, ib.s_wen, ib.owner,
                  ib.m0_rdata, ib.m1_rdata, ib.s_addr, ib.s_wdata, ib.s_be};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int rl_of(int k);
    return (k != 0) ? RL_B : RL_A;
  endfunction

  function automatic int mb_of(int k);
    return (k != 0) ? MB_B : MB_A;
  endfunction

  // Reference model: consecutive-grant run length per owner and a response calendar keyed by due cycle.
  bit lo[2];
  int run[2];
  bit busy[2];
  bit eg[2], ew[2], ewe[2];
  bit pv[2][8];
  bit pid[2][8];
  int cyc = 0;

  always @(negedge clk) begin
    obs_t e;
    bit w;
    int s;
    #2;
    for (int k = 0; k < 2; k++) begin
      e = '0;
      eg[k] = 1'b0;
      if (!resetn) begin
        e.own = 1'b1;
      end else begin
        s = cyc % 8;
        if (pv[k][s]) begin
          if (pid[k][s]) begin e.rv1 = 1'b1; e.rd1 = s_rdata; end
          else begin e.rv0 = 1'b1; e.rd0 = s_rdata; end
        end
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) w = (!busy[k] || run[k] >= mb_of(k)) ? !lo[k] : lo[k];
          else w = m1_req;
          eg[k] = 1'b1;
          ew[k] = w;
          ewe[k] = w ? m1_we : m0_we;
          e.g0 = !w;
          e.g1 = w;
          e.own = w;
          e.ren = !ewe[k];
          e.wen = ewe[k];
          e.addr = w ? m1_addr : m0_addr;
          e.wdata = w ? m1_wdata : m0_wdata;
          e.be = w ? m1_be : m0_be;
        end else begin
          e.own = lo[k];
        end
      end
      chk((k != 0) ? "model_b" : "model_a", 160'((k != 0) ? obs_b : obs_a), 160'(e));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!resetn) begin
        lo[k] <= 1'b1;
        run[k] <= 0;
        busy[k] <= 1'b0;
        for (int j = 0; j < 8; j++) pv[k][j] <= 1'b0;
      end else begin
        pv[k][cyc % 8] <= 1'b0;
        if (eg[k]) begin
          run[k] <= (busy[k] && ew[k] == lo[k]) ? run[k] + 1 : 1;
          lo[k] <= ew[k];
          busy[k] <= 1'b1;
          if (!ewe[k]) begin
            pv[k][(cyc + rl_of(k)) % 8] <= 1'b1;
            pid[k][(cyc + rl_of(k)) % 8] <= ew[k];
          end
        end else begin
          busy[k] <= 1'b0;
          run[k] <= 0;
        end
      end
    end
    cyc <= cyc + 1;
  end

  typedef struct {
    logic        r0, r1, w0, w1;
    logic        g0, g1, own, ren, wen;
    logic [31:0] addr;
  } vec_t;

  function automatic vec_t v(logic r0, logic r1, logic w0, logic w1, logic g0, logic g1,
                             logic own, logic ren, logic wen, logic [31:0] addr);
    vec_t t;
    t.r0 = r0; t.r1 = r1; t.w0 = w0; t.w1 = w1;
    t.g0 = g0; t.g1 = g1; t.own = own; t.ren = ren; t.wen = wen; t.addr = addr;
    return t;
  endfunction

  vec_t tbl[$];
  obs_t rz;

  initial begin
    // Dut a (MAX_BURST 4): both stream reads -> m0 x4, m1 x4, m0 x4; then idle tie-break and writes.
    for (int i = 0; i < 12; i++) begin
      if ((i / 4) % 2 == 0) tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 1, 0, 32'h100));
      else                  tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 1, 0, 32'h200));
    end
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 1, 0, 32'h200));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 0, 0, 1, 0, 0, 1, 0, 32'h100));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 1, 0, 32'h200));
    tbl.push_back(v(1, 0, 1, 0, 1, 0, 0, 0, 1, 32'h100));
    tbl.push_back(v(1, 1, 1, 0, 1, 0, 0, 0, 1, 32'h100));

    rz = '0;
    rz.own = 1'b1;

    m0_req = 1'b1; m1_req = 1'b1;
    m0_addr = 32'h100; m1_addr = 32'h200;
    m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000;
    m0_be = 4'h3; m1_be = 4'hC;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset_a", 160'(obs_a), 160'(rz));
    chk("reset_b", 160'(obs_b), 160'(rz));
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      m0_req = tbl[i].r0; m1_req = tbl[i].r1; m0_we = tbl[i].w0; m1_we = tbl[i].w1;
      #2;
      chk($sformatf("tbl_row%0d", i),
          160'({ia.m0_gnt, ia.m1_gnt, ia.owner, ia.s_ren, ia.s_wen, ia.s_addr}),
          160'({tbl[i].g0, tbl[i].g1, tbl[i].own, tbl[i].ren, tbl[i].wen, tbl[i].addr}));
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      m0_req = (i < 3);
      m0_addr = 32'h10 + 32'(4 * i);
      s_rdata = (i >= 1 && i <= 3) ? 32'hA + 32'(i - 1) : 32'h0;
      #2;
      chk("stream_gnt", 160'(ia.m0_gnt), 160'(i < 3));
      chk("stream_rsp", 160'({ia.m0_rvalid, ia.m1_rvalid, ia.m0_rdata}),
          160'({(i >= 1 && i <= 3), 1'b0, s_rdata}));
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hDEAD_BEEF; m0_be = 4'hF;
    #2;
    chk("wr_cycle", 160'({ia.m0_gnt, ia.s_wen, ia.s_ren, ia.s_wdata, ia.s_be, ia.s_addr}),
        160'({1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 32'h40}));
    @(negedge clk);
    m0_req = 1'b0; m0_we = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
    #2;
    chk("rd_cycle", 160'({ia.m1_gnt, ia.s_ren, ia.s_wen, ia.m0_rvalid, ia.s_addr}),
        160'({1'b1, 1'b1, 1'b0, 1'b0, 32'h44}));
    @(negedge clk);
    m1_req = 1'b0; s_rdata = 32'h5A5A_0044;
    #2;
    chk("rd_resp", 160'({ia.m0_rvalid, ia.m1_rvalid, ia.m1_rdata}), 160'({1'b0, 1'b1, 32'h5A5A_0044}));
    repeat (5) @(negedge clk);

    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h80;
    #2;
    chk("b_rd_issue", 160'({ib.m1_gnt, ib.s_ren}), 160'(2'b11));
    @(negedge clk);
    m1_req = 1'b0;
    resetn = 1'b0;
    #2;
    chk("b_in_reset", 160'(obs_b), 160'(rz));
    chk("a_in_reset", 160'(obs_a), 160'(rz));
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("b_no_stale_rvalid", 160'({ib.m0_rvalid, ib.m1_rvalid}), 160'(0));
      @(negedge clk);
    end

    // Random traffic; each master holds its request until the model says dut a granted it.
    for (int c = 0; c < 3000; c++) begin
      if (!m0_req || (eg[0] && !ew[0])) begin
        m0_req = ($urandom_range(0, 3) != 0);
        m0_we = 1'($urandom_range(0, 1));
        m0_addr = $urandom; m0_wdata = $urandom; m0_be = 4'($urandom);
      end
      if (!m1_req || (eg[0] && ew[0])) begin
        m1_req = ($urandom_range(0, 3) != 0);
        m1_we = 1'($urandom_range(0, 1));
        m1_addr = $urandom; m1_wdata = $urandom; m1_be = 4'($urandom);
      end
      s_rdata = $urandom;
      resetn = (c != 1500);
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter sharing the single main-memory data port between the CPU data interface (master 0) and a DMA/loader engine (master 1, e.g. flash-to-RAM copy or USB transfer). It sits between the masters and the address decoder's memory port and issues at most one access per cycle. Fairness is round-robin with a bounded burst length, and read responses are returned to the issuing master after the fixed memory read latency.

## Interface
- READ_LAT, 1: memory read latency in cycles, from `s_ren` to valid `s_rdata`; legal range 1..4.
- MAX_BURST, 8: maximum consecutive grants to one master while the other is requesting; legal range 1..255.
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  access request; held until granted.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_be, m1_be  in  4  byte enables.
- m0_gnt, m1_gnt  out  1  combinational accept; the access is issued this cycle.
- m0_rvalid, m1_rvalid  out  1  read data valid for that master.
- m0_rdata, m1_rdata  out  32  read data; equals `s_rdata` when rvalid is high, 0 otherwise.
- s_ren, s_wen  out  1  memory read and write strobes.
- s_addr  out  32  memory address.
- s_wdata  out  32  memory write data.
- s_be  out  4  memory byte enables.
- s_rdata  in  32  memory read data.
- owner  out  1  master granted this cycle; holds last_owner when idle.

## Operation
- **Registered state**
  - last_owner (1 bit)
  - burst_cnt (8 bits)
  - tag pipeline: READ_LAT stages of {valid, id}
- **Arbitration** (combinational from the requests and registered state)
  - Only one master requesting: that master is granted.
  - Both requesting:
    - If burst_cnt == MAX_BURST, the master other than last_owner wins.
    - Otherwise last_owner wins, so a continuing stream is kept.
    - Exception, ties right after reset or after an idle cycle: the master other than last_owner wins (round-robin).
  - Neither requesting: no grant, and all s_* strobes are 0.
- **Granted access** (master gX)
  - `s_ren = ~mX_we`, `s_wen = mX_we`.
  - s_addr, s_wdata and s_be are muxed from master X.
  - When no master is granted, the s_* data outputs are 0.
- **burst_cnt update** on a grant to X
  - X == last_owner and the previous cycle was a grant: saturating increment.
  - Otherwise: load 1.
  - Then last_owner <= X.
  - Idle cycle: burst_cnt <= 0 and last_owner is kept.
- **Read tracking**
  - A granted read pushes {1, X} into tag stage 0.
  - Writes and idle cycles push {0, -}.
  - The tags shift one stage per cycle.
  - At the last stage, valid drives mX_rvalid for id X.
- **Writes** produce no response; the grant is the completion.
- Masters must keep req, we, addr, wdata and be stable until granted. The arbiter does not check this.

## Timing
- **Grant latency:** 0 cycles. gnt is asserted in the same cycle as req when the master wins.
- **Read response:** mX_rvalid is asserted exactly READ_LAT cycles after the granting edge, for one cycle per read.
- **Throughput:** back-to-back reads from different masters are supported, one per cycle. Responses are returned in issue order.
- **Worst-case wait** for a requesting master: MAX_BURST cycles.
- **Reset values** (when resetn = 0):
  - Registers: last_owner = 1 (so master 0 wins the first tie), burst_cnt = 0, all tags invalid.
  - Outputs: all gnt, rvalid, rdata and s_* outputs are 0; owner = 1.
- **Reset mid-operation:** in-flight reads are dropped and no rvalid is ever issued for them. Operation resumes on the first edge after resetn rises.
- **Simultaneous events:**
  - A request dropping in the same cycle as burst_cnt reaching MAX_BURST: no effect. The count resets on the next grant to the other master or on an idle cycle.
  - A grant and a response to the same master in the same cycle are independent.
- **Saturation:** burst_cnt never exceeds MAX_BURST.

## Test plan
1. **Reset and first tie.** Release reset, then assert m0_req (read, addr 0x100) and m1_req (read, addr 0x200) together. Required: m0_gnt = 1 in cycle 0 with s_addr = 0x100 and s_ren = 1. m1_gnt follows once the burst limit is reached or m0 drops its request.
2. **Single-master read stream.** With READ_LAT = 1, m0 reads 0x10, 0x14 and 0x18 on consecutive cycles, and memory returns 0xA, 0xB and 0xC. Required: m0_rvalid is high for 3 cycles, starting 1 cycle after the first grant, with data 0xA, 0xB, 0xC. m1_rvalid stays 0 throughout.
3. **Burst limit.** MAX_BURST = 4; m0 and m1 both request continuously. Required grant sequence: m0 ×4, m1 ×4, m0 ×4, with owner toggling accordingly.
4. **Interleaved read/write.** m0 writes 0xDEADBEEF to 0x40 with be = 0xF; in the next cycle m1 reads 0x44. Required:
   - Write cycle: s_wen = 1, s_wdata = 0xDEADBEEF, s_be = 0xF.
   - Read cycle: s_ren = 1.
   - Responses: m1_rvalid only, and m0_rvalid stays 0.
5. **Reset mid-read.** With READ_LAT = 3, m1 issues a read, and resetn is pulsed low one cycle later. Required: all outputs read 0 during reset, and no m1_rvalid appears afterwards.
6. **Idle tie-break.** m1 is granted once, then one idle cycle, then both masters request. Required: m0_gnt = 1 (the master other than last_owner wins), and burst_cnt restarts at 1.
